// File: rtl/cassette_recorder_if.sv
// SDRAM write port shared by the cassette recorder and its memory side.
// Master drives address/data/request; slave returns a one-cycle ack.
interface cassette_recorder_if;
  logic [24:0] sdram_addr;
  logic [7:0]  sdram_wdata;
  logic        sdram_wr;
  logic        sdram_ack;

  modport master (
    output sdram_addr, sdram_wdata, sdram_wr,
    input  sdram_ack
  );

  modport slave (
    input  sdram_addr, sdram_wdata, sdram_wr,
    output sdram_ack
  );
endinterface

// File: rtl/cassette_recorder.sv
// MC-10 CSAVE decoder: FSK period detect, leader/sync lock,
// byte image written upward into the SDRAM tape region.
module cassette_recorder #(
  parameter int unsigned MIN_PERIOD = 3000,
  parameter int unsigned BIT_THRESH = 7954,
  parameter int unsigned MAX_PERIOD = 20000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       record,
  input  logic                       rewind,
  input  logic                       cas_in,
  cassette_recorder_if.master        sdram,
  output logic                       recording,
  output logic [24:0]                tape_len,
  output logic                       overrun
);

  localparam logic [15:0] MIN_P = 16'(MIN_PERIOD);
  localparam logic [15:0] THR_P = 16'(BIT_THRESH);
  localparam logic [15:0] MAX_P = 16'(MAX_PERIOD);
  localparam logic [39:0] EOF_SEQ = 40'h3CFF00FF55;

  typedef enum logic [1:0] {
    IDLE, HUNT, LEADER, DATA
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  sync_q, sync_d;
  logic        rec_q, rec_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bvld_q, bvld_d;
  logic        bit_q, bit_d;
  logic [15:0] win_q, win_d;
  logic [2:0]  bcnt_q, bcnt_d;
  logic [39:0] seq_q, seq_d;
  logic        wr_q, wr_d;
  logic        pend_q, pend_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [24:0] addr_q, addr_d;
  logic [24:0] len_q, len_d;
  logic        ovr_q, ovr_d;
  logic        recd_q, recd_d;

  logic        rise;
  logic        rec_rise;
  logic        gap;
  logic [15:0] win_sh;
  logic [7:0]  byte_nxt;
  logic [39:0] seq_sh;
  logic        req;
  logic [7:0]  req_data;

  assign rise     = sync_q[1] & ~sync_q[2];
  assign rec_rise = record & ~rec_q;
  assign gap      = (cnt_q == MAX_P);
  assign win_sh   = {bit_q, win_q[15:1]};
  assign byte_nxt = win_sh[15:8];
  assign seq_sh   = {seq_q[31:0], byte_nxt};

  always_comb begin
    sync_d = {sync_q[1:0], cas_in};
    rec_d  = record;
    cnt_d  = gap ? cnt_q : cnt_q + 16'd1;
    bvld_d = 1'b0;
    bit_d  = bit_q;
    if (rise && cnt_q >= MIN_P) begin
      bvld_d = 1'b1;
      bit_d  = (cnt_q < THR_P);
      cnt_d  = 16'd1;
    end

    state_d  = state_q;
    win_d    = win_q;
    bcnt_d   = bcnt_q;
    seq_d    = seq_q;
    req      = 1'b0;
    req_data = 8'h00;
    unique case (state_q)
      IDLE: begin
        win_d = '0;
        if (rec_rise) state_d = HUNT;
      end
      HUNT: begin
        if (bvld_q) begin
          win_d = win_sh;
          if (win_sh == 16'h5555) begin
            state_d = LEADER;
            bcnt_d  = 3'd0;
          end
        end
      end
      LEADER: begin
        if (bvld_q) begin
          win_d  = win_sh;
          bcnt_d = bcnt_q + 3'd1;
          if (byte_nxt == 8'h3C) begin
            req      = 1'b1;
            req_data = 8'h3C;
            bcnt_d   = 3'd0;
            seq_d    = {32'h0, 8'h3C};
            state_d  = DATA;
          end else if (bcnt_q == 3'd7) begin
            if (byte_nxt == 8'h55) begin
              req      = 1'b1;
              req_data = 8'h55;
            end else begin
              state_d = HUNT;
            end
          end
        end
      end
      DATA: begin
        if (bvld_q) begin
          win_d  = win_sh;
          bcnt_d = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) begin
            req      = 1'b1;
            req_data = byte_nxt;
            seq_d    = seq_sh;
            if (seq_sh == EOF_SEQ) state_d = IDLE;
          end
        end else if (gap) begin
          state_d = HUNT;
        end
      end
    endcase
    if (state_q != IDLE && !record) begin
      state_d = IDLE;
      req     = 1'b0;
    end
    recd_d = (state_d != IDLE);

    wr_d    = wr_q;
    pend_d  = pend_q;
    wdata_d = wdata_q;
    addr_d  = addr_q;
    len_d   = len_q;
    ovr_d   = ovr_q;
    if (wr_q && sdram.sdram_ack) begin
      wr_d   = 1'b0;
      addr_d = addr_q + 25'd1;
      len_d  = len_q + 25'd1;
    end
    if (pend_q) begin
      wr_d   = 1'b1;
      pend_d = 1'b0;
    end
    // Byte landing on the ack cycle is parked one cycle, not dropped.
    if (req) begin
      if ((wr_q && !sdram.sdram_ack) || pend_q) begin
        ovr_d = 1'b1;
      end else if (wr_q) begin
        pend_d  = 1'b1;
        wdata_d = req_data;
      end else begin
        wr_d    = 1'b1;
        wdata_d = req_data;
      end
    end
    if (state_q == IDLE && rec_rise) ovr_d = 1'b0;
    if (state_q == IDLE && rewind) begin
      addr_d = '0;
      len_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      sync_q  <= '0;
      rec_q   <= 1'b0;
      cnt_q   <= '0;
      bvld_q  <= 1'b0;
      bit_q   <= 1'b0;
      win_q   <= '0;
      bcnt_q  <= '0;
      seq_q   <= '0;
      wr_q    <= 1'b0;
      pend_q  <= 1'b0;
      wdata_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      ovr_q   <= 1'b0;
      recd_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      rec_q   <= rec_d;
      cnt_q   <= cnt_d;
      bvld_q  <= bvld_d;
      bit_q   <= bit_d;
      win_q   <= win_d;
      bcnt_q  <= bcnt_d;
      seq_q   <= seq_d;
      wr_q    <= wr_d;
      pend_q  <= pend_d;
      wdata_q <= wdata_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      ovr_q   <= ovr_d;
      recd_q  <= recd_d;
    end
  end

  assign sdram.sdram_addr  = addr_q;
  assign sdram.sdram_wdata = wdata_q;
  assign sdram.sdram_wr    = wr_q;
  assign recording         = recd_q;
  assign tape_len          = len_q;
  assign overrun           = ovr_q;

endmodule

// File: tb/tb_cassette_recorder.sv
// Directed bench for cassette_recorder with scaled-down periods
// so whole CSAVE streams fit in a short run.
module tb_cassette_recorder;

  localparam int MINP = 30;
  localparam int THR  = 80;
  localparam int MAXP = 200;
  localparam int P1   = 60;
  localparam int P0   = 120;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        record = 1'b0;
  logic        rewind = 1'b0;
  logic        cas_in = 1'b0;
  logic        recording;
  logic        overrun;
  logic [24:0] tape_len;

  cassette_recorder_if bus();

  cassette_recorder #(
    .MIN_PERIOD(MINP),
    .BIT_THRESH(THR),
    .MAX_PERIOD(MAXP)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .record   (record),
    .rewind   (rewind),
    .cas_in   (cas_in),
    .sdram    (bus.master),
    .recording(recording),
    .tape_len (tape_len),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  int nw = 0;
  int ack_dly = 0;
  logic [7:0]  wdat [64];
  logic [24:0] wadr [64];
  logic [7:0]  e [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Memory side: log each write, ack after ack_dly cycles.
  initial begin
    bus.sdram_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.sdram_wr === 1'b1 && reset_n) begin
        if (nw < 64) begin
          wdat[nw] = bus.sdram_wdata;
          wadr[nw] = bus.sdram_addr;
        end
        nw++;
        repeat (ack_dly) @(negedge clk);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
      end
    end
  end

  task automatic send_bit(input logic b, input bit g);
    int p;
    p = b ? P1 : P0;
    cas_in = 1'b1;
    if (g) begin
      repeat (5) @(negedge clk);
      cas_in = 1'b0;
      repeat (10) @(negedge clk);
      cas_in = 1'b1;
      repeat (p / 2 - 15) @(negedge clk);
    end else begin
      repeat (p / 2) @(negedge clk);
    end
    cas_in = 1'b0;
    repeat (p / 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit g);
    for (int i = 0; i < 8; i++) send_bit(v[i], g);
  endtask

  task automatic lead_in();
    cas_in = 1'b0;
    repeat (MAXP + 20) @(negedge clk);
  endtask

  task automatic leader();
    for (int i = 0; i < 4; i++) send_byte(8'h55, 1'b0);
    send_byte(8'h3C, 1'b0);
  endtask

  task automatic trail();
    cas_in = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic arm();
    record = 1'b0;
    repeat (2) @(negedge clk);
    record = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_log(input string tag, input int i0, input int a0);
    for (int i = 0; i < e.size(); i++) begin
      chk({tag, "_data"}, 32'(wdat[i0 + i]), 32'(e[i]));
      chk({tag, "_addr"}, 32'(wadr[i0 + i]), a0 + i);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_addr", 32'(bus.sdram_addr), 0);
    chk("rst_wdata", 32'(bus.sdram_wdata), 0);
    chk("rst_wr", 32'(bus.sdram_wr), 0);
    chk("rst_rec", 32'(recording), 0);
    chk("rst_len", 32'(tape_len), 0);
    chk("rst_ovr", 32'(overrun), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Leader lock, sync, two data bytes
    arm();
    chk("t1_rec_on", 32'(recording), 1);
    lead_in();
    leader();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    trail();
    chk("t1_nw", nw, 5);
    e = '{8'h55, 8'h55, 8'h3C, 8'h00, 8'h01};
    chk_log("t1", 0, 0);
    chk("t1_len", 32'(tape_len), 5);
    chk("t1_addr", 32'(bus.sdram_addr), 5);
    chk("t1_ovr", 32'(overrun), 0);
    record = 1'b0;
    repeat (2) @(negedge clk);
    chk("t1_rec_off", 32'(recording), 0);

    // End-of-file block stops recording
    arm();
    lead_in();
    leader();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'hFF, 1'b0);
    send_byte(8'h55, 1'b0);
    cas_in = 1'b1;
    for (int i = 0; i < 40 && recording; i++) @(negedge clk);
    chk("t2_rec_fall", 32'(recording), 0);
    repeat (20) @(negedge clk);
    chk("t2_nw", nw, 13);
    e = '{8'h55, 8'h55, 8'h3C, 8'h3C,
          8'hFF, 8'h00, 8'hFF, 8'h55};
    chk_log("t2", 5, 5);
    chk("t2_len", 32'(tape_len), 13);
    send_byte(8'h55, 1'b0);
    send_byte(8'h55, 1'b0);
    trail();
    chk("t2_idle_nw", nw, 13);
    chk("t2_idle_rec", 32'(recording), 0);

    // Glitches inside data bits
    arm();
    lead_in();
    leader();
    send_byte(8'hA5, 1'b1);
    send_byte(8'h5A, 1'b1);
    trail();
    chk("t3_nw", nw, 18);
    e = '{8'h55, 8'h55, 8'h3C, 8'hA5, 8'h5A};
    chk_log("t3", 13, 13);
    chk("t3_ovr", 32'(overrun), 0);
    record = 1'b0;

    // Slow ack: second leader byte is dropped
    ack_dly = 760;
    arm();
    lead_in();
    leader();
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    trail();
    repeat (1000) @(negedge clk);
    chk("t4_nw", nw, 22);
    e = '{8'h55, 8'h3C, 8'h11, 8'h22};
    chk_log("t4", 18, 18);
    chk("t4_ovr", 32'(overrun), 1);
    chk("t4_len", 32'(tape_len), 22);
    ack_dly = 0;
    record = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_ovr_sticky", 32'(overrun), 1);

    // Rewind in IDLE
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    @(negedge clk);
    chk("rw_addr", 32'(bus.sdram_addr), 0);
    chk("rw_len", 32'(tape_len), 0);
    chk("rw_ovr_kept", 32'(overrun), 1);

    // Gap in DATA, then a new block appends
    arm();
    chk("t5_ovr_clr", 32'(overrun), 0);
    lead_in();
    leader();
    send_byte(8'h01, 1'b0);
    trail();
    repeat (300) @(negedge clk);
    rewind = 1'b1;
    @(negedge clk);
    rewind = 1'b0;
    @(negedge clk);
    chk("t5_rewind_ign", 32'(bus.sdram_addr), 4);
    lead_in();
    leader();
    send_byte(8'h02, 1'b0);
    trail();
    chk("t5_nw", nw, 30);
    e = '{8'h55, 8'h55, 8'h3C, 8'h01,
          8'h55, 8'h55, 8'h3C, 8'h02};
    chk_log("t5", 22, 0);
    chk("t5_len", 32'(tape_len), 8);
    chk("t5_rec", 32'(recording), 1);

    // Reset while a write is pending
    arm();
    lead_in();
    leader();
    send_byte(8'h01, 1'b0);
    ack_dly = 3000;
    cas_in = 1'b1;
    for (int i = 0; i < 40 && !bus.sdram_wr; i++) @(negedge clk);
    chk("t6_wr_seen", 32'(bus.sdram_wr), 1);
    chk("t6_addr_pre", 32'(bus.sdram_addr), 11);
    reset_n = 1'b0;
    @(negedge clk);
    chk("t6_wr", 32'(bus.sdram_wr), 0);
    chk("t6_addr", 32'(bus.sdram_addr), 0);
    chk("t6_rec", 32'(recording), 0);
    chk("t6_len", 32'(tape_len), 0);
    reset_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
